// File: rtl/alu_sequencer_z.sv
// Sequencer around the 64-bit ALU. It latches an operation request and holds the
// opcode on the ALU. It waits a per-opcode latency, captures RZ into ZHI/ZLO and
// then pulses done for one cycle.
module alu_sequencer_z #(
    parameter int unsigned DIV_CYCLES = 34,
    parameter int unsigned MUL_CYCLES = 1,
    parameter int unsigned OP_CYCLES  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  opcode,
    input  logic [63:0] RZ,
    output logic [4:0]  alu_op,
    output logic        div_clr,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic [31:0] ZHI,
    output logic [31:0] ZLO
);

    localparam logic [4:0] OpMul = 5'b00010;
    localparam logic [4:0] OpDiv = 5'b00011;

    // Counter preloads are latency minus one because the capture edge is the one seen at zero.
    localparam logic [5:0] DivCntInit = 6'(DIV_CYCLES - 1);
    localparam logic [5:0] MulCntInit = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] OpCntInit  = 6'(OP_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [4:0]  alu_op_q, alu_op_d;
    logic        div_clr_q, div_clr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        illegal_q, illegal_d;
    logic [31:0] zhi_q, zhi_d;
    logic [31:0] zlo_q, zlo_d;

    logic        opcode_legal;
    logic [5:0]  cnt_init;

    // Decode which opcodes the ALU supports.
    always_comb begin
        opcode_legal = (opcode <= 5'd9) || (opcode == 5'd11) || (opcode == 5'd12) ||
                       (opcode == 5'd13);
    end

    // Select the latency preload for the requested opcode.
    always_comb begin
        unique case (opcode)
            OpDiv:   cnt_init = DivCntInit;
            OpMul:   cnt_init = MulCntInit;
            default: cnt_init = OpCntInit;
        endcase
    end

    // Next-state and registered-output logic. div_clr and done default low so each is a pulse.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        alu_op_d  = alu_op_q;
        div_clr_d = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        illegal_d = illegal_q;
        zhi_d     = zhi_q;
        zlo_d     = zlo_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    busy_d = 1'b1;
                    if (opcode_legal) begin
                        alu_op_d  = opcode;
                        illegal_d = 1'b0;
                        cnt_d     = cnt_init;
                        div_clr_d = (opcode == OpDiv);
                        state_d   = StWait;
                    end else begin
                        // Unsupported opcode: flag it and finish without touching alu_op or Z.
                        illegal_d = 1'b1;
                        done_d    = 1'b1;
                        state_d   = StDone;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 6'd0) begin
                    zhi_d   = RZ[63:32];
                    zlo_d   = RZ[31:0];
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            StDone: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; reset clears everything immediately, even mid-divide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= 6'd0;
            alu_op_q  <= 5'd0;
            div_clr_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            zhi_q     <= 32'd0;
            zlo_q     <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            alu_op_q  <= alu_op_d;
            div_clr_q <= div_clr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
            zhi_q     <= zhi_d;
            zlo_q     <= zlo_d;
        end
    end

    assign alu_op  = alu_op_q;
    assign div_clr = div_clr_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign illegal = illegal_q;
    assign ZHI     = zhi_q;
    assign ZLO     = zlo_q;

endmodule

// File: tb/tb_alu_sequencer_z.sv
// Directed bench for alu_sequencer_z. RZ is driven with hand-computed ALU results.
module tb_alu_sequencer_z;

    logic        clk;
    logic        reset;
    logic        start;
    logic [4:0]  opcode;
    logic [63:0] RZ;
    logic [4:0]  alu_op;
    logic        div_clr;
    logic        busy;
    logic        done;
    logic        illegal;
    logic [31:0] ZHI;
    logic [31:0] ZLO;

    int checks = 0;
    int errors = 0;

    alu_sequencer_z #(
        .DIV_CYCLES(34),
        .MUL_CYCLES(1),
        .OP_CYCLES (1)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .opcode (opcode),
        .RZ     (RZ),
        .alu_op (alu_op),
        .div_clr(div_clr),
        .busy   (busy),
        .done   (done),
        .illegal(illegal),
        .ZHI    (ZHI),
        .ZLO    (ZLO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          busy_cnt;
        logic        z_moved;
        logic [8:0]  done_v;
        logic [8:0]  busy_v;
        logic [4:0]  dec_op [4];
        logic        dec_ill [4];

        reset = 1'b1; start = 1'b0; opcode = 5'd0; RZ = 64'd0;
        repeat (2) tick();
        chk("reset_ctrl", 64'({alu_op, div_clr, busy, done, illegal}), 64'd0);
        chk("reset_z", {ZHI, ZLO}, 64'd0);
        reset = 1'b0;

        // Add 5+7: single-cycle latency
        opcode = 5'b00000; RZ = 64'h0000_0000_0000_000C; start = 1'b1;
        tick(); start = 1'b0;                                  // E0
        chk("add_alu_op_e0", 64'(alu_op), 64'd0);
        chk("add_busy_e0", 64'(busy), 64'd1);
        chk("add_done_e0", 64'(done), 64'd0);
        tick();                                                // E1
        chk("add_zlo_e1", 64'(ZLO), 64'h0C);
        chk("add_zhi_e1", 64'(ZHI), 64'h0);
        chk("add_done_e1", 64'(done), 64'd1);
        tick();                                                // E2
        chk("add_done_e2", 64'(done), 64'd0);
        chk("add_busy_e2", 64'(busy), 64'd0);

        // Divide 100/7: capture at E34, busy for 35 cycles, stray start ignored
        opcode = 5'b00011; RZ = 64'hDEAD_BEEF_DEAD_BEEF; start = 1'b1;
        tick(); start = 1'b0;                                  // E0
        chk("div_clr_e0", 64'(div_clr), 64'd1);
        chk("div_alu_op_e0", 64'(alu_op), 64'd3);
        busy_cnt = busy ? 1 : 0;
        z_moved = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            tick();
            if (k == 1) chk("div_clr_e1", 64'(div_clr), 64'd0);
            if (busy) busy_cnt++;
            if (ZLO !== 32'h0C || ZHI !== 32'h0 || done !== 1'b0) z_moved = 1'b1;
            if (k == 4) begin start = 1'b1; opcode = 5'b00000; end
            if (k == 5) begin start = 1'b0; opcode = 5'b00111; end
        end
        chk("div_no_early_z", 64'(z_moved), 64'd0);
        RZ = 64'h0000_0002_0000_000E;
        tick();                                                // E34
        if (busy) busy_cnt++;
        chk("div_zlo_e34", 64'(ZLO), 64'd14);
        chk("div_zhi_e34", 64'(ZHI), 64'd2);
        chk("div_done_e34", 64'(done), 64'd1);
        chk("div_alu_op_held", 64'(alu_op), 64'd3);
        tick();                                                // E35
        chk("div_busy_cycles", 64'(busy_cnt), 64'd35);
        chk("div_busy_e35", 64'(busy), 64'd0);

        // Illegal opcode after an add result of 0x0C
        opcode = 5'b00000; RZ = 64'h0C; start = 1'b1;
        tick(); start = 1'b0; tick(); tick();
        opcode = 5'b01010; RZ = 64'hFFFF_FFFF_FFFF_FFFF; start = 1'b1;
        tick(); start = 1'b0;                                  // E0
        chk("ill_flag_e0", 64'(illegal), 64'd1);
        chk("ill_done_e0", 64'(done), 64'd1);
        chk("ill_busy_e0", 64'(busy), 64'd1);
        chk("ill_alu_op", 64'(alu_op), 64'd0);
        chk("ill_zlo", 64'(ZLO), 64'h0C);
        tick();                                                // E1
        chk("ill_done_e1", 64'(done), 64'd0);
        chk("ill_busy_e1", 64'(busy), 64'd0);
        chk("ill_sticky", 64'(illegal), 64'd1);
        opcode = 5'b01101; RZ = 64'h5; start = 1'b1;
        tick(); start = 1'b0;
        chk("ill_cleared", 64'(illegal), 64'd0);
        chk("ill_next_op", 64'(alu_op), 64'd13);
        tick();
        chk("ill_next_zlo", 64'(ZLO), 64'h5);
        tick();

        // start held: AND 0xF0F0F0F0 & 0xFF00FF00, one accept every 3 cycles
        opcode = 5'b00100; RZ = 64'h0000_0000_F000_F000; start = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            done_v[k] = done;
            busy_v[k] = busy;
        end
        start = 1'b0;
        chk("b2b_done_pattern", 64'(done_v), 64'(9'b010010010));
        chk("b2b_busy_pattern", 64'(busy_v), 64'(9'b011011011));
        chk("b2b_zlo", 64'(ZLO), 64'hF000_F000);
        chk("b2b_alu_op", 64'(alu_op), 64'd4);

        // Async reset in the middle of a divide
        opcode = 5'b00011; RZ = 64'h1234_5678_9ABC_DEF0; start = 1'b1;
        tick(); start = 1'b0;
        repeat (10) tick();
        #3 reset = 1'b1;
        #1;
        chk("mid_reset_ctrl", 64'({alu_op, div_clr, busy, done, illegal}), 64'd0);
        chk("mid_reset_z", {ZHI, ZLO}, 64'd0);
        tick();
        reset = 1'b0;
        opcode = 5'b00000; RZ = 64'h0C; start = 1'b1;
        tick(); start = 1'b0;
        chk("post_rst_busy_e0", 64'(busy), 64'd1);
        chk("post_rst_done_e0", 64'(done), 64'd0);
        tick();
        chk("post_rst_done_e1", 64'(done), 64'd1);
        chk("post_rst_zlo", 64'(ZLO), 64'h0C);
        tick();
        chk("post_rst_busy_e2", 64'(busy), 64'd0);

        // Negate 1: sign-extended all-ones result
        opcode = 5'b01100; RZ = 64'hFFFF_FFFF_FFFF_FFFF; start = 1'b1;
        tick(); start = 1'b0;
        tick();
        chk("neg_zlo", 64'(ZLO), 64'hFFFF_FFFF);
        chk("neg_zhi", 64'(ZHI), 64'hFFFF_FFFF);
        tick();

        // Opcode legality at the decode boundaries
        dec_op[0] = 5'b01001; dec_ill[0] = 1'b0;
        dec_op[1] = 5'b01110; dec_ill[1] = 1'b1;
        dec_op[2] = 5'b11111; dec_ill[2] = 1'b1;
        dec_op[3] = 5'b01011; dec_ill[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            opcode = dec_op[i]; RZ = 64'h0; start = 1'b1;
            tick(); start = 1'b0;
            chk($sformatf("decode_%0d", dec_op[i]), 64'(illegal), 64'(dec_ill[i]));
            for (int w = 0; w < 5 && busy; w++) tick();
            chk($sformatf("decode_idle_%0d", dec_op[i]), 64'(busy), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
